reorder_in: RTL
===============

# reorder_in

Input-side reorder buffer for the NTT datapath: accepts one coefficient per handshake from the upstream source, stores a full 2^NUM_STAGES-point frame, then delivers coefficient pairs (top/bottom butterfly operands) to the NTT core on `next_pair` requests. It sits in front of the first butterfly stage and mirrors the output-side reorder logic, which collects pairs and releases them serially. It holds its own frame storage and returns data, not just addresses.

## Interface
- `NUM_STAGES`, 4, log2 of frame length N (N = 2^NUM_STAGES, N/2 pairs)
- `DATA_WIDTH`, 16, coefficient width in bits

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream coefficient valid
- `in_data`  in  DATA_WIDTH  upstream coefficient
- `in_ready`  out  1  block accepts a coefficient this cycle
- `next_pair`  in  1  NTT core requests the next butterfly pair
- `restart`  in  1  single-cycle pulse: begin loading a new frame
- `pair_valid`  out  1  `out_top`/`out_bot`/`pair_idx` valid this cycle
- `out_top`  out  DATA_WIDTH  top operand, buffer address {0, pair_idx}
- `out_bot`  out  DATA_WIDTH  bottom operand, buffer address {1, pair_idx}
- `pair_idx`  out  NUM_STAGES-1  index of the delivered pair
- `done`  out  1  all N/2 pairs of the frame delivered

## Operation
- Storage: N x DATA_WIDTH register array; write counter `wr_cnt` (NUM_STAGES bits), pair counter `pr_cnt` (NUM_STAGES-1 bits).
- States: LOAD, DRAIN, DONE. Reset -> LOAD.
- LOAD: `in_ready`=1. On `in_valid && in_ready`: mem[wr_addr] <= `in_data`, `wr_cnt` += 1. Accept with `wr_cnt`==N-1 -> DRAIN, `wr_cnt` wraps to 0. `next_pair` ignored.
- DRAIN: `in_ready`=0. On `next_pair`: `out_top` <= mem[{1'b0, pr_cnt}], `out_bot` <= mem[{1'b1, pr_cnt}], `pair_idx` <= `pr_cnt`, `pair_valid` <= 1, `pr_cnt` += 1. `next_pair` with `pr_cnt`==N/2-1 -> DONE, `pr_cnt` wraps to 0.
- DONE: `done`=1, `in_ready`=0, `next_pair` ignored. `restart` -> LOAD (counters already 0). `restart` in LOAD/DRAIN ignored.
- `in_valid` while `in_ready`=0: data dropped, no state change.
- Reset at any time: state LOAD, both counters 0, `pair_valid`=0, `out_top`/`out_bot`/`pair_idx`=0, `done`=0. Memory contents not cleared; a partially loaded frame is discarded.

## Timing
- `in_ready` and `done` are decoded from the registered state: no combinational path from any input.
- Last accepted coefficient in cycle k -> `in_ready`=0 from k+1; earliest honored `next_pair` is at k+1.
- `next_pair` in cycle t -> `pair_valid`=1 with data in t+1 for exactly one cycle unless `next_pair` is repeated. Back-to-back `next_pair` gives one pair per cycle.
- Final `next_pair` in cycle t -> `pair_valid` and `done` both 1 in t+1; `done` stays high until `restart` or reset.
- `restart` in cycle t (DONE) -> `in_ready`=1 in t+1.
- Outputs hold their last values when `pair_valid`=0.
- Minimum frame turnaround: N load cycles + N/2 drain cycles + 1 restart cycle.

## Configuration
- `REORDER_IN_BITREV_EN` defined: wr_addr = bit-reverse of `wr_cnt` over NUM_STAGES bits, so the core receives bit-reversed-order operands for DIT.
- Not defined: wr_addr = `wr_cnt` (natural order). Pair read addressing is identical in both builds.

## Test plan
- Natural build, N=16, feed 100..115 with continuous `in_valid`, then 8 back-to-back `next_pair` -> pairs (100,108),(101,109)...(107,115), `pair_idx` 0..7, `done`=1 with the last pair.
- `REORDER_IN_BITREV_EN` build, same stimulus -> pair0 (100,101), pair1 (108,109), pair7 (114,115).
- `in_valid` toggled randomly plus `next_pair` asserted during LOAD -> exactly 16 writes, no `pair_valid` before DRAIN; `in_valid` after the 16th accept has no effect.
- `reset` after 9 accepted samples, then a full 16-sample frame of 200..215 -> pairs come only from the new frame: (200,208)...(207,215).
- In DONE, `next_pair` held high for 3 cycles -> no `pair_valid`. `restart` pulse -> `in_ready`=1 next cycle. A second frame loads and drains correctly.
- `restart` pulsed during LOAD and during DRAIN -> ignored, counters and pair sequence unaffected.

Source files
------------

// File: rtl/reorder_in.sv
// ============================================================================
// Module   : reorder_in
// Purpose  : Input-side reorder buffer for the NTT datapath. Loads one
//            2^NUM_STAGES-point frame serially, then hands butterfly operand
//            pairs (addresses {0,idx} and {1,idx}) to the NTT core on request.
// Options  : REORDER_IN_BITREV_EN - when defined, coefficients are written at
//            the bit-reversed write count (bit-reversed operand order for DIT).
//            When undefined, coefficients are stored in natural order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_in #(
  parameter int NUM_STAGES = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  next_pair,
  input  logic                  restart,
  output logic                  pair_valid,
  output logic [DATA_WIDTH-1:0] out_top,
  output logic [DATA_WIDTH-1:0] out_bot,
  output logic [NUM_STAGES-2:0] pair_idx,
  output logic                  done
);

  localparam int N  = 1 << NUM_STAGES;
  localparam int PW = NUM_STAGES - 1;

  // Terminal counts: last write of a frame and last pair of a frame.
  localparam logic [NUM_STAGES-1:0] WR_LAST = {NUM_STAGES{1'b1}};
  localparam logic [PW-1:0]         PR_LAST = {PW{1'b1}};

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q,      state_d;
  logic [NUM_STAGES-1:0] wr_cnt_q,     wr_cnt_d;
  logic [PW-1:0]         pr_cnt_q,     pr_cnt_d;
  logic                  pair_valid_q, pair_valid_d;
  logic [DATA_WIDTH-1:0] out_top_q,    out_top_d;
  logic [DATA_WIDTH-1:0] out_bot_q,    out_bot_d;
  logic [PW-1:0]         pair_idx_q,   pair_idx_d;

  // Frame storage; deliberately not reset, a new frame simply overwrites it.
  logic [DATA_WIDTH-1:0] mem [N];

  logic [NUM_STAGES-1:0] wr_addr;
  logic                  wr_en;
  logic [NUM_STAGES-1:0] rd_addr_top;
  logic [NUM_STAGES-1:0] rd_addr_bot;

`ifdef REORDER_IN_BITREV_EN
  // Write address is the write count with its bit order reversed.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_bitrev
    assign wr_addr[gi] = wr_cnt_q[NUM_STAGES-1-gi];
  end
`else
  assign wr_addr = wr_cnt_q;
`endif

  // Pair read addressing is the same in both builds: top half / bottom half.
  assign rd_addr_top = {1'b0, pr_cnt_q};
  assign rd_addr_bot = {1'b1, pr_cnt_q};

  // Accepting only in LOAD; input data outside LOAD is dropped.
  assign wr_en = in_valid && (state_q == S_LOAD);

  // Status outputs are pure decodes of the registered state.
  assign in_ready   = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign pair_valid = pair_valid_q;
  assign out_top    = out_top_q;
  assign out_bot    = out_bot_q;
  assign pair_idx   = pair_idx_q;

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    pr_cnt_d     = pr_cnt_q;
    pair_valid_d = 1'b0;
    out_top_d    = out_top_q;
    out_bot_d    = out_bot_q;
    pair_idx_d   = pair_idx_q;

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == WR_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (next_pair) begin
          out_top_d    = mem[rd_addr_top];
          out_bot_d    = mem[rd_addr_bot];
          pair_idx_d   = pr_cnt_q;
          pair_valid_d = 1'b1;
          pr_cnt_d     = pr_cnt_q + 1'b1;
          if (pr_cnt_q == PR_LAST) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Both counters have already wrapped to zero on the way here.
        if (restart) begin
          state_d = S_LOAD;
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      wr_cnt_q     <= '0;
      pr_cnt_q     <= '0;
      pair_valid_q <= 1'b0;
      out_top_q    <= '0;
      out_bot_q    <= '0;
      pair_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      pr_cnt_q     <= pr_cnt_d;
      pair_valid_q <= pair_valid_d;
      out_top_q    <= out_top_d;
      out_bot_q    <= out_bot_d;
      pair_idx_q   <= pair_idx_d;
    end
  end

  // Frame storage write port; reset intentionally leaves contents untouched.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= in_data;
    end
  end

endmodule

`default_nettype wire
